// File: rtl/slow_tick_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : slow_tick_bcd_counter
// Description : Samples the divider's slow square wave as data, turns each
//               rising edge into a one-cycle tick and advances a two-digit
//               modulo-MODULO BCD up/down counter with a rollover pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module slow_tick_bcd_counter #(
    parameter int SYNC_STAGES = 2,   // synchronizer depth on slower_clk, 2..4
    parameter int MODULO      = 60   // count range 0..MODULO-1, 2..100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       slower_clk,
    input  logic       en,
    input  logic       up_dn,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       wrap
);

    // Terminal count split into its BCD digits.
    localparam int         c_term      = MODULO - 1;
    localparam logic [3:0] c_term_tens = 4'(c_term / 10);
    localparam logic [3:0] c_term_ones = 4'(c_term % 10);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   tick_q, tick_d;
    logic                   wrap_q, wrap_d;
    logic [3:0]             tens_q, tens_d;
    logic [3:0]             ones_q, ones_d;

    logic w_sync;
    logic w_rise;

    // Synchronizer chain: stage 0 samples the raw input, each later stage
    // takes the one before it.
    assign sync_d[0] = slower_clk;
    for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync_stage
        assign sync_d[i] = sync_q[i-1];
    end

    assign w_sync = sync_q[SYNC_STAGES-1];
    assign w_rise = w_sync & ~hist_q;

    // Edge history and tick pulse; tick ignores en/clr on purpose.
    always_comb begin
        hist_d = w_sync;
        tick_d = w_rise;
    end

    // BCD count update; clear beats a coincident tick.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        wrap_d = 1'b0;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (w_rise && en) begin
            if (up_dn) begin
                if (tens_q == c_term_tens && ones_q == c_term_ones) begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (tens_q == 4'd0 && ones_q == 4'd0) begin
                    tens_d = c_term_tens;
                    ones_d = c_term_ones;
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // State registers. Synchronizer and history reset to 1 so a level that is
    // already high when reset releases is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_tick_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_slow_tick_bcd_counter
// Description : Scoreboard bench for slow_tick_bcd_counter. Each generated
//               rising edge of slower_clk pushes the expected tick cycle and
//               count; the monitor pops and compares whenever tick is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slow_tick_bcd_counter;

    localparam int SYNC_STAGES = 2;
    localparam int MODULO      = 60;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       slower_clk;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       tick;
    logic       wrap;

    typedef struct {
        int cyc;
        int tens;
        int ones;
        int wrap;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   model    = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_on   = 1'b0;

    slow_tick_bcd_counter #(
        .SYNC_STAGES (SYNC_STAGES),
        .MODULO      (MODULO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .slower_clk (slower_clk),
        .en         (en),
        .up_dn      (up_dn),
        .clr        (clr),
        .tens       (tens),
        .ones       (ones),
        .tick       (tick),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every tick must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_on) begin
            if (tick) begin
                if (sb.size() == 0) begin
                    check("spurious_tick", 32'(tick), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("tick_cycle", 32'(cyc), 32'(e.cyc));
                    check("tens", 32'(tens), 32'(e.tens));
                    check("ones", 32'(ones), 32'(e.ones));
                    check("wrap", 32'(wrap), 32'(e.wrap));
                end
            end else begin
                check("wrap_idle", 32'(wrap), 32'd0);
                if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                    void'(sb.pop_front());
                    check("tick_missing", 32'(tick), 32'd1);
                end
            end
        end
    end

    // One slower_clk period: low for lo cycles, high for hi cycles (hi >= 4).
    // The expected result is computed from the inputs held across the tick.
    task automatic pulse(input int lo, input int hi, input bit clr_on_tick);
        exp_t e;
        int   w;
        slower_clk = 1'b0;
        repeat (lo) @(negedge clk);
        slower_clk = 1'b1;
        w = 0;
        if (clr_on_tick) begin
            model = 0;
        end else if (en) begin
            if (up_dn) begin
                if (model == MODULO - 1) begin model = 0; w = 1; end
                else model = model + 1;
            end else begin
                if (model == 0) begin model = MODULO - 1; w = 1; end
                else model = model - 1;
            end
        end
        e.cyc  = cyc + SYNC_STAGES + 1;
        e.tens = model / 10;
        e.ones = model % 10;
        e.wrap = w;
        sb.push_back(e);
        for (int k = 0; k < hi; k++) begin
            clr = clr_on_tick && (k == SYNC_STAGES);
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse(5, 5, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        slower_clk = 1'b1;
        en         = 1'b1;
        up_dn      = 1'b1;
        clr        = 1'b0;

        // Reset with slower_clk already high: no tick afterwards.
        @(negedge clk);
        mon_on = 1'b1;
        check("rst_tens", 32'(tens), 32'd0);
        check("rst_ones", 32'(ones), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("held_tens", 32'(tens), 32'd0);
        check("held_ones", 32'(ones), 32'd0);
        model = 0;

        // Up count to terminal, then the wrapping tick.
        pulses(59);
        check("term_tens", 32'(tens), 32'd5);
        check("term_ones", 32'(ones), 32'd9);
        check("term_wrap", 32'(wrap), 32'd0);
        pulses(1);
        check("after_wrap_tens", 32'(tens), 32'd0);

        // Down count with BCD borrow and underflow wrap.
        pulses(10);
        check("ten_tens", 32'(tens), 32'd1);
        check("ten_ones", 32'(ones), 32'd0);
        up_dn = 1'b0;
        pulses(10);
        pulses(1);
        check("under_tens", 32'(tens), 32'd5);
        check("under_ones", 32'(ones), 32'd9);

        // Clear coinciding with a tick at 4,2.
        up_dn = 1'b1;
        pulses(43);
        check("pre_clr_tens", 32'(tens), 32'd4);
        check("pre_clr_ones", 32'(ones), 32'd2);
        pulse(5, 5, 1'b1);

        // Enable low: ticks still pulse, count holds.
        pulses(3);
        en = 1'b0;
        pulses(5);
        check("hold_ones", 32'(ones), 32'd3);
        en = 1'b1;

        // Idle clear without a tick.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model = 0;
        check("idle_clr_ones", 32'(ones), 32'd0);

        // Long high level gives one tick.
        pulse(5, 50, 1'b0);

        // Reset mid-count at 3,7.
        pulses(36);
        check("pre_rst_tens", 32'(tens), 32'd3);
        check("pre_rst_ones", 32'(ones), 32'd7);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tens", 32'(tens), 32'd0);
        check("mid_rst_ones", 32'(ones), 32'd0);
        reset_n = 1'b1;
        model = 0;
        repeat (5) @(negedge clk);
        pulses(2);
        check("post_rst_ones", 32'(ones), 32'd2);

        repeat (10) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
